// File: rtl/mutex_requester.sv
// Requester side of a four-phase req/gnt mutex handshake: synchronizes the
// asynchronous grant, holds the critical section for a programmed count, and
// gives up with a timeout pulse if the grant never arrives.
module mutex_requester #(
  parameter int HOLD_W      = 8,
  parameter int TO_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [TO_W-1:0]   to_limit,
  output logic              req,
  input  logic              gnt,
  output logic              busy,
  output logic              in_cs,
  output logic              done,
  output logic              timeout
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_REL, S_FIN} state_t;

  state_t            r_state;
  logic [SYNC_N-1:0] r_sync;
  logic [HOLD_W-1:0] r_hold_lim;
  logic [HOLD_W-1:0] r_hold;
  logic [TO_W-1:0]   r_to_lim;
  logic [TO_W-1:0]   r_wait;
  logic              r_to_flag;
  logic              r_req;
  logic              r_busy;
  logic              r_in_cs;
  logic              r_done;
  logic              r_timeout;

  logic              w_gnt_s;
  logic              w_wait_hit;
  logic [TO_W-1:0]   w_wait_inc;
  logic [HOLD_W-1:0] w_hold_load;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_N-2:0], gnt};
  end

  assign w_gnt_s     = r_sync[SYNC_N-1];
  // wait counter starts at 1 on entry, so a limit of N gives N cycles in REQ
  assign w_wait_hit  = (r_to_lim != '0) && (r_wait == r_to_lim);
  assign w_wait_inc  = (r_wait == '1) ? r_wait : r_wait + TO_W'(1);
  // the count runs down to 0 inclusive, so load one less; 0 still yields one cycle
  assign w_hold_load = (r_hold_lim == '0) ? '0 : r_hold_lim - HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_lim <= '0;
      r_hold     <= '0;
      r_to_lim   <= '0;
      r_wait     <= '0;
      r_to_flag  <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_in_cs    <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_REQ;
            r_hold_lim <= hold_cycles;
            r_to_lim   <= to_limit;
            r_wait     <= TO_W'(1);
            r_req      <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_gnt_s) begin
            r_state <= S_HOLD;
            r_hold  <= w_hold_load;
            r_in_cs <= 1'b1;
          end else if (w_wait_hit) begin
            r_state   <= S_REL;
            r_to_flag <= 1'b1;
            r_req     <= 1'b0;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        // grant is deliberately not looked at here: a premature drop must not
        // cut the critical section short
        S_HOLD: begin
          if (r_hold == '0) begin
            r_state <= S_REL;
            r_req   <= 1'b0;
            r_in_cs <= 1'b0;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        S_REL: begin
          if (!w_gnt_s) begin
            r_state   <= S_FIN;
            r_done    <= 1'b1;
            r_timeout <= r_to_flag;
          end
        end
        S_FIN: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_to_flag <= 1'b0;
          r_wait    <= '0;
          r_hold    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_in_cs <= 1'b0;
        end
      endcase
    end
  end

  assign req     = r_req;
  assign busy    = r_busy;
  assign in_cs   = r_in_cs;
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mutex_requester.sv
// Directed bench: two requesters share a registered mutex model; requester A
// can also be driven from a forced grant to script exact handshake timing.
module tb_mutex_requester;
  localparam int HW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [HW-1:0] hold_a = '0, hold_b = '0;
  logic [TW-1:0] to_a = '0, to_b = '0;
  logic          req_a, req_b, busy_a, busy_b, in_cs_a, in_cs_b;
  logic          done_a, done_b, tmo_a, tmo_b;
  logic          gnt_a, gnt_b;
  logic          tb_force = 1'b0, tb_gval = 1'b0;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mutex_requester #(.HOLD_W(HW), .TO_W(TW), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .hold_cycles(hold_a), .to_limit(to_a),
    .req(req_a), .gnt(gnt_a), .busy(busy_a), .in_cs(in_cs_a), .done(done_a), .timeout(tmo_a));

  mutex_requester #(.HOLD_W(HW), .TO_W(TW), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .hold_cycles(hold_b), .to_limit(to_b),
    .req(req_b), .gnt(gnt_b), .busy(busy_b), .in_cs(in_cs_b), .done(done_b), .timeout(tmo_b));

  // mutex model: one-cycle grant latency, A has priority, released on req drop
  always @(posedge clk) begin
    if (rst) owner <= 2'd0;
    else case (owner)
      2'd0:    if (req_a) owner <= 2'd1; else if (req_b) owner <= 2'd2;
      2'd1:    if (!req_a) owner <= 2'd0;
      2'd2:    if (!req_b) owner <= 2'd0;
      default: owner <= 2'd0;
    endcase
  end
  assign gnt_a = tb_force ? tb_gval : (owner == 2'd1);
  assign gnt_b = (owner == 2'd2);

  int n_req_a = 0, n_incs_a = 0, n_incs_b = 0, n_done_a = 0, n_done_b = 0;
  int n_to_a = 0, n_to_b = 0, n_ovl = 0;
  always @(posedge clk) begin
    if (req_a)              n_req_a++;
    if (in_cs_a)            n_incs_a++;
    if (in_cs_b)            n_incs_b++;
    if (done_a)             n_done_a++;
    if (done_b)             n_done_b++;
    if (tmo_a)              n_to_a++;
    if (tmo_b)              n_to_b++;
    if (in_cs_a && in_cs_b) n_ovl++;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s_req, s_incs, s_done, s_to;
  task automatic snap();
    s_req = n_req_a; s_incs = n_incs_a; s_done = n_done_a; s_to = n_to_a;
  endtask

  // A through the mutex model; returns the cycle done was seen (0 = never)
  task automatic run_mutex(input int hold, input int tol, input int bound,
                           output int n_done, output logic req1);
    tb_force = 1'b0;
    hold_a = HW'(hold); to_a = TW'(tol); start_a = 1'b1;
    n_done = 0; req1 = 1'b0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (n == 1) req1 = req_a;
      if (done_a) begin n_done = n; break; end
    end
  endtask

  // A with a scripted grant: raised at cycle on_n, dropped at drop_n or K
  // cycles after req falls
  task automatic run_forced(input int hold, input int tol, input int on_n, input int drop_n,
                            input int k, input int bound, output int n_done, output logic req1);
    int   fcnt;
    bit   fell;
    logic prev_req;
    tb_force = 1'b1; tb_gval = 1'b0;
    hold_a = HW'(hold); to_a = TW'(tol); start_a = 1'b1;
    n_done = 0; req1 = 1'b0; fcnt = 0; fell = 1'b0; prev_req = 1'b0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (n == 1) req1 = req_a;
      if (n == on_n) tb_gval = 1'b1;
      if (n == drop_n) tb_gval = 1'b0;
      if (fell) fcnt++;
      if (prev_req && !req_a && !fell) begin fell = 1'b1; fcnt = 0; end
      if (fell && fcnt == k) tb_gval = 1'b0;
      prev_req = req_a;
      if (done_a) begin n_done = n; break; end
    end
    tb_gval = 1'b0;
  endtask

  int   nd, sb_done, sb_incs, sb_to;
  logic r1;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", req_a, 0);    chk("rst_busy", busy_a, 0);  chk("rst_incs", in_cs_a, 0);
    chk("rst_done", done_a, 0);  chk("rst_tmo", tmo_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", req_a, 0); chk("post_rst_busy", busy_a, 0); chk("post_rst_req_b", req_b, 0);

    // grant high while idle is ignored
    snap();
    tb_force = 1'b1; tb_gval = 1'b1;
    idle(6);
    chk("idle_gnt_req", req_a, 0); chk("idle_gnt_busy", busy_a, 0); chk("idle_gnt_incs", in_cs_a, 0);
    tb_gval = 1'b0;
    idle(4);
    chk("idle_gnt_done", n_done_a - s_done, 0);

    // normal grant, hold 3, no timeout
    snap();
    run_mutex(3, 0, 50, nd, r1);
    chk("norm_req_next", r1, 1);       chk("norm_lat", nd, 12);
    chk("norm_tmo", tmo_a, 0);         chk("norm_busy_fin", busy_a, 1);
    @(negedge clk);
    chk("norm_busy_idle", busy_a, 0);  chk("norm_done_pulse", done_a, 0);
    idle(2);
    chk("norm_req_cyc", n_req_a - s_req, 7);
    chk("norm_incs_cyc", n_incs_a - s_incs, 3);
    chk("norm_done_cnt", n_done_a - s_done, 1);

    // timeout after 5 cycles without grant
    snap();
    run_forced(2, 5, 0, 0, 0, 50, nd, r1);
    chk("to5_lat", nd, 7);  chk("to5_tmo", tmo_a, 1);  chk("to5_req_now", req_a, 0);
    idle(3);
    chk("to5_req_cyc", n_req_a - s_req, 5);
    chk("to5_incs", n_incs_a - s_incs, 0);
    chk("to5_to_cnt", n_to_a - s_to, 1);

    // largest limit does not wrap
    snap();
    run_forced(1, 255, 0, 0, 0, 400, nd, r1);
    chk("to255_lat", nd, 257);  chk("to255_tmo", tmo_a, 1);
    idle(3);
    chk("to255_req_cyc", n_req_a - s_req, 255);

    // grant reaches the FSM in the same cycle as expiry: grant wins
    snap();
    run_forced(2, 4, 2, 0, 0, 50, nd, r1);
    chk("race_lat", nd, 10);  chk("race_tmo", tmo_a, 0);
    idle(3);
    chk("race_incs", n_incs_a - s_incs, 2);
    chk("race_req_cyc", n_req_a - s_req, 6);
    chk("race_to_cnt", n_to_a - s_to, 0);

    // slow release: grant held 4 cycles after req falls
    snap();
    run_forced(1, 0, 1, 0, 4, 50, nd, r1);
    chk("slow_lat", nd, 12);  chk("slow_tmo", tmo_a, 0);
    idle(3);
    chk("slow_incs", n_incs_a - s_incs, 1);
    chk("slow_done_cnt", n_done_a - s_done, 1);

    // grant dropped mid-hold does not shorten the section
    snap();
    run_forced(4, 0, 1, 4, 100, 50, nd, r1);
    chk("drop_lat", nd, 9);
    idle(3);
    chk("drop_incs", n_incs_a - s_incs, 4);

    // hold 0 acts as 1; starts while busy and in FIN are ignored
    snap();
    tb_force = 1'b0; hold_a = '0; to_a = '0; start_a = 1'b1; nd = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start_a = (n == 3 || n == 5 || n == 10);
      hold_a  = (n == 1) ? HW'(7) : hold_a;
      if (done_a && nd == 0) nd = n;
    end
    start_a = 1'b0;
    chk("h0_lat", nd, 10);
    chk("h0_incs", n_incs_a - s_incs, 1);
    chk("h0_done_cnt", n_done_a - s_done, 1);
    chk("h0_busy_end", busy_a, 0);

    // two requesters contending
    snap();
    sb_done = n_done_b; sb_incs = n_incs_b; sb_to = n_to_b;
    tb_force = 1'b0; hold_a = HW'(3); hold_b = HW'(2); to_a = '0; to_b = '0;
    start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    idle(60);
    chk("dual_overlap", n_ovl, 0);
    chk("dual_done_a", n_done_a - s_done, 1);
    chk("dual_done_b", n_done_b - sb_done, 1);
    chk("dual_to_a", n_to_a - s_to, 0);
    chk("dual_to_b", n_to_b - sb_to, 0);
    chk("dual_incs_a", n_incs_a - s_incs, 3);
    chk("dual_incs_b", n_incs_b - sb_incs, 2);

    // reset while holding, then a clean transaction
    snap();
    tb_force = 1'b0; hold_a = HW'(5); to_a = '0; start_a = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("rsth_in_hold", in_cs_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rsth_req", req_a, 0);  chk("rsth_busy", busy_a, 0);
    chk("rsth_incs", in_cs_a, 0);  chk("rsth_done", done_a, 0);
    idle(10);
    chk("rsth_no_done", n_done_a - s_done, 0);
    snap();
    run_mutex(2, 0, 50, nd, r1);
    chk("rsth_next_lat", nd, 11);  chk("rsth_next_tmo", tmo_a, 0);
    idle(3);
    chk("rsth_next_incs", n_incs_a - s_incs, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
